// File: rtl/alu_cmd_issuer.sv
// Command FIFO feeding a registered ALU: issues one command at a time, waits
// ALU_LAT cycles for the result, then holds it until the consumer accepts it.
module alu_cmd_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [7:0]                   cmd_ab,
    input  logic [3:0]                   cmd_op,
    output logic [3:0]                   alu_a,
    output logic [3:0]                   alu_b,
    output logic [3:0]                   alu_op,
    input  logic [7:0]                   alu_res,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [7:0]                   res_data,
    output logic [3:0]                   res_op,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [11:0]   mem [FIFO_DEPTH];
    logic [11:0]   head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          push, pop, capture, res_done;
    logic          empty, full;

    assign empty     = (level == '0);
    assign full      = (level == (PW + 1)'(FIFO_DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr];
    assign busy      = (state_q != IDLE) || !empty;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        capture  = 1'b0;
        res_done = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (cnt == '0) begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (res_ready) begin
                res_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_ab, cmd_op};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_data  <= '0;
            res_op    <= '0;
            res_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr                <= rd_ptr + 1'b1;
                {alu_a, alu_b, alu_op} <= head;
                cnt                   <= CW'(ALU_LAT);
            end else if (state_q == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
            if (capture) begin
                res_data  <= alu_res;
                res_op    <= alu_op;
                res_valid <= 1'b1;
            end else if (res_done) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 Parameter ALU_LAT, default 1, ALU clock cycles from operand change to registered result (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command FIFO can accept; equals !full.
REQ-007 cmd_ab  input  8  operands: [7:4]=A, [3:0]=B.
REQ-008 cmd_op  input  4  ALU opcode.
REQ-009 alu_a  output  4  operand A to ALU.
REQ-010 alu_b  output  4  operand B to ALU.
REQ-011 alu_op  output  4  opcode to ALU.
REQ-012 alu_res  input  8  registered ALU result.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  result consumer accepts.
REQ-015 res_data  output  8  captured ALU result.
REQ-016 res_op  output  4  opcode that produced res_data.
REQ-017 busy  output  1  high when FSM not IDLE or FIFO non-empty.
REQ-018 level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-019 Command accepted on edge where cmd_valid && cmd_ready; {cmd_ab,cmd_op} written at write pointer, pointer wraps mod FIFO_DEPTH.
REQ-020 FSM states IDLE, WAIT, HOLD only.
REQ-021 IDLE with FIFO non-empty: at the edge, pop head into alu_a/alu_b/alu_op registers, load counter with ALU_LAT, go WAIT.
REQ-022 IDLE with FIFO empty: stay IDLE; alu_* hold last values.
REQ-023 WAIT, counter!=0: decrement counter each edge.
REQ-024 WAIT, counter==0: capture alu_res into res_data and alu_op into res_op, assert res_valid, go HOLD.
REQ-025 alu_a/alu_b/alu_op stable from pop edge until next pop.
REQ-026 HOLD: res_valid, res_data, res_op stable while res_ready low.
REQ-027 HOLD with res_ready high: at edge deassert res_valid, go IDLE; no pop in that same cycle.
REQ-028 Latency: command accepted at edge N into empty FIFO with FSM IDLE -> popped at edge N+1, res_valid high after edge N+2+ALU_LAT.
REQ-029 Push and pop in same cycle legal; level unchanged; FIFO content order preserved.
REQ-030 Push when full impossible (cmd_ready low); cmd_valid ignored, no overwrite.
REQ-031 Pop when empty never occurs; pointers never advance on empty.
REQ-032 Results emitted in command acceptance order; one result per command; no drop, no duplicate.
REQ-033 level = pushes minus pops, range 0..FIFO_DEPTH.

Reset
REQ-034 rst_n low at edge: FSM->IDLE, pointers and level->0, counter->0, alu_a/alu_b/alu_op->0, res_data/res_op->0, res_valid->0, busy->0; cmd_ready->1 after edge.
REQ-035 Reset mid-operation (WAIT or HOLD) discards in-flight command and all queued commands; no result emitted for them.
REQ-036 rst_n overrides all other inputs in the same cycle.

Verification (bench models ALU with ALU_LAT-cycle registered output)
REQ-037 Single add: cmd_ab=0x93, cmd_op=0x0, res_ready=1 -> res_valid after accept edge +3 (ALU_LAT=1), res_data=0x0C, res_op=0x0.
REQ-038 Back-to-back: push (0x75,op2),(0xF1,op3),(0x5A,op8) -> results 0x23, 0x0F, 0x00 in order, each with matching res_op.
REQ-039 Backpressure/full: res_ready=0, push continuously -> exactly FIFO_DEPTH+1 (5) commands accepted, cmd_ready low, level=4; release res_ready -> 5 results in order, cmd_ready re-asserts after first pop.
REQ-040 Hold stability: res_ready low 10 cycles in HOLD -> res_data/res_op/res_valid unchanged every cycle.
REQ-041 Reset mid-WAIT with 2 queued: rst_n low one cycle -> next cycle level=0, res_valid=0, busy=0, alu_*=0; no result appears for discarded commands.
REQ-042 ALU_LAT=3 build: single command -> res_valid after accept edge +5; alu_* stable throughout.
